// File: rtl/vc_pkg.sv
// ----------------------------------------------------------------------------
// vc_pkg
// Shared definitions for the virtual-channel arbiter and its output stage:
//   - arb_state_e        : arbiter FSM states (which VC, if any, was popped)
//   - GNT_NONE/VC0/VC1   : one-hot {VC1,VC0} grant encodings
//   - DATA_WIDTH_DEFAULT : default FIFO word width
// ----------------------------------------------------------------------------
package vc_pkg;

    localparam int DATA_WIDTH_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERV0 = 2'd1,
        SERV1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_VC0  = 2'b01;
    localparam logic [1:0] GNT_VC1  = 2'b10;

endpackage

// File: rtl/vc_out_stage.sv
// ----------------------------------------------------------------------------
// vc_out_stage
// Push/mux stage toward the downstream FIFO. The pop select arrives already
// registered (it is the arbiter FSM state, which records the VC popped in the
// previous cycle), and the VC FIFOs present their read data exactly one cycle
// after the pop, so the push strobe, grant and data all line up here without
// a second register. Outputs are forced to zero while reset is asserted so an
// in-flight word is dropped rather than pushed.
//
// Ports:
//   reset        in   synchronous active-low reset (used here as a push gate)
//   served_i     in   registered pop select (IDLE / SERV0 / SERV1)
//   vc0_data_i   in   VC0 FIFO read data
//   vc1_data_i   in   VC1 FIFO read data
//   out_push_o   out  downstream write enable
//   out_data_o   out  downstream write data, zero when not pushing
//   grant_o      out  one-hot {VC1,VC0} of the word being pushed
// ----------------------------------------------------------------------------
module vc_out_stage
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  reset,
    input  arb_state_e            served_i,
    input  logic [DATA_WIDTH-1:0] vc0_data_i,
    input  logic [DATA_WIDTH-1:0] vc1_data_i,
    output logic                  out_push_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [1:0]            grant_o
);

    always_comb begin
        grant_o    = GNT_NONE;
        out_data_o = '0;
        if (reset) begin
            case (served_i)
                SERV0: begin
                    grant_o    = GNT_VC0;
                    out_data_o = vc0_data_i;
                end
                SERV1: begin
                    grant_o    = GNT_VC1;
                    out_data_o = vc1_data_i;
                end
                default: begin
                    grant_o    = GNT_NONE;
                    out_data_o = '0;
                end
            endcase
        end
    end

    assign out_push_o = (grant_o != GNT_NONE);

endmodule

// File: rtl/vc_arbiter.sv
// ----------------------------------------------------------------------------
// vc_arbiter
// Drains two virtual-channel FIFOs into one downstream FIFO. VC0 has strict
// priority; after MAX_VC0_BURST consecutive VC0 pops while VC1 is waiting,
// one VC1 word is forced through. Pops are combinational; the matching push
// follows one cycle later through vc_out_stage.
//
// Optional build macro: VC_ARBITER_STATS_EN adds per-channel push counters
// (vc0_grant_cnt, vc1_grant_cnt) and a starve_event pulse.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   vc0_empty/vc1_empty  VC FIFO empty flags
//   vc0_data/vc1_data    VC FIFO read data (valid the cycle after a pop)
//   out_full, out_almost_full  downstream FIFO status
//   vc0_pop/vc1_pop      VC FIFO read enables
//   out_push, out_data   downstream write enable / data
//   grant                one-hot {VC1,VC0} of the word pushed this cycle
//   vc0_grant_cnt, vc1_grant_cnt, starve_event  (stats build only)
// ----------------------------------------------------------------------------
module vc_arbiter
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int MAX_VC0_BURST = 4,
    parameter int BURST_CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  out_full,
    input  logic                  out_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  out_push,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            grant
`ifdef VC_ARBITER_STATS_EN
    ,
    output logic [15:0]           vc0_grant_cnt,
    output logic [15:0]           vc1_grant_cnt,
    output logic                  starve_event
`endif
);

    localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_VC0_BURST);

    arb_state_e             state_q, state_d;
    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic                   pop_ok;
    logic                   vc0_allowed;

    // Stop popping one entry early: the push trails the pop by a cycle and
    // the downstream count only moves after that push.
    assign pop_ok      = !out_full && !out_almost_full;
    assign vc0_allowed = vc1_empty || (burst_q < BURST_MAX);

    always_comb begin
        state_d = IDLE;
        if (!reset) begin
            state_d = IDLE;
        end else if (!pop_ok) begin
            state_d = IDLE;
        end else if (!vc0_empty && vc0_allowed) begin
            state_d = SERV0;
        end else if (!vc1_empty) begin
            state_d = SERV1;
        end else begin
            state_d = IDLE;
        end
    end

    assign vc0_pop = (state_d == SERV0);
    assign vc1_pop = (state_d == SERV1);

    // The burst count only measures VC0 pops that VC1 had to wait through;
    // a stall holds it so backpressure cannot reset the fairness window.
    always_comb begin
        burst_d = burst_q;
        if (vc1_pop || vc1_empty) begin
            burst_d = '0;
        end else if (vc0_pop && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    vc_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .reset      (reset),
        .served_i   (state_q),
        .vc0_data_i (vc0_data),
        .vc1_data_i (vc1_data),
        .out_push_o (out_push),
        .out_data_o (out_data),
        .grant_o    (grant)
    );

`ifdef VC_ARBITER_STATS_EN
    logic [15:0] vc0_cnt_q, vc0_cnt_d;
    logic [15:0] vc1_cnt_q, vc1_cnt_d;

    always_comb begin
        vc0_cnt_d = vc0_cnt_q;
        vc1_cnt_d = vc1_cnt_q;
        if (out_push && (grant == GNT_VC0)) begin
            vc0_cnt_d = vc0_cnt_q + 16'd1;
        end
        if (out_push && (grant == GNT_VC1)) begin
            vc1_cnt_d = vc1_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vc0_cnt_q <= '0;
            vc1_cnt_q <= '0;
        end else begin
            vc0_cnt_q <= vc0_cnt_d;
            vc1_cnt_q <= vc1_cnt_d;
        end
    end

    assign vc0_grant_cnt = vc0_cnt_q;
    assign vc1_grant_cnt = vc1_cnt_q;
    // VC1 winning while VC0 still has data can only be the burst limit.
    assign starve_event  = vc1_pop && !vc0_empty;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vc_arbiter
// Randomised scoreboard bench for vc_arbiter. The bench owns behavioural
// models of both VC FIFOs and the downstream FIFO, decides from the
// arbitration rules which VC should be popped each cycle, and queues the
// expected push (channel + word). A negedge monitor compares pops each cycle
// and pops the scoreboard whenever the DUT pushes.
// ----------------------------------------------------------------------------
module tb_vc_arbiter;
    import vc_pkg::*;

    localparam int DW   = 6;
    localparam int MAXB = 4;
    localparam int CAP  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vc0_empty = 1'b1;
    logic          vc1_empty = 1'b1;
    logic [DW-1:0] vc0_data = '0;
    logic [DW-1:0] vc1_data = '0;
    logic          out_full = 1'b0;
    logic          out_almost_full = 1'b0;
    logic          vc0_pop, vc1_pop, out_push;
    logic [DW-1:0] out_data;
    logic [1:0]    grant;
`ifdef VC_ARBITER_STATS_EN
    logic [15:0]   vc0_grant_cnt, vc1_grant_cnt;
    logic          starve_event;
`endif

    vc_arbiter #(
        .DATA_WIDTH    (DW),
        .MAX_VC0_BURST (MAXB),
        .BURST_CNT_W   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .vc0_empty       (vc0_empty),
        .vc1_empty       (vc1_empty),
        .vc0_data        (vc0_data),
        .vc1_data        (vc1_data),
        .out_full        (out_full),
        .out_almost_full (out_almost_full),
        .vc0_pop         (vc0_pop),
        .vc1_pop         (vc1_pop),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant           (grant)
`ifdef VC_ARBITER_STATS_EN
        ,
        .vc0_grant_cnt   (vc0_grant_cnt),
        .vc1_grant_cnt   (vc1_grant_cnt),
        .starve_event    (starve_event)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    g;
        logic [DW-1:0] d;
    } exp_t;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    exp_t          sb[$];
    bit            dut_log[$];

    int            errors = 0;
    int            checks = 0;
    int            streak = 0;      // VC0 words served while VC1 waited
    int            ds_cnt = 0;      // downstream FIFO occupancy
    int            drain_pct = 100;
    bit            force_af = 1'b0;
    bit            exp0 = 1'b0;
    bit            exp1 = 1'b0;
    bit            seen_push = 1'b0;
    bit            log_en = 1'b0;
    logic [DW-1:0] d0_n = '0;
    logic [DW-1:0] d1_n = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void drive();
        vc0_data        = d0_n;
        vc1_data        = d1_n;
        vc0_empty       = (q0.size() == 0);
        vc1_empty       = (q1.size() == 0);
        out_full        = (ds_cnt >= CAP);
        out_almost_full = (ds_cnt == CAP - 1) || force_af;
    endfunction

    function automatic void load(input int n0, input int n1);
        for (int i = 0; i < n0; i++) q0.push_back(DW'($urandom));
        for (int i = 0; i < n1; i++) q1.push_back(DW'($urandom));
        drive();
    endfunction

    // Monitor: expected pops from the arbitration rules, pushes from the scoreboard.
    always @(negedge clk) begin
        bit   pok, e0, e1;
        exp_t e;
        pok = !out_full && !out_almost_full;
        e0  = 1'b0;
        e1  = 1'b0;
        if (reset && pok) begin
            if (q0.size() > 0 && (q1.size() == 0 || streak < MAXB)) e0 = 1'b1;
            else if (q1.size() > 0) e1 = 1'b1;
        end
        exp0 = e0;
        exp1 = e1;
        chk("vc0_pop", {31'd0, vc0_pop}, {31'd0, e0});
        chk("vc1_pop", {31'd0, vc1_pop}, {31'd0, e1});
        if (!reset) begin
            sb.delete();
            chk("push_in_reset", {31'd0, out_push}, 32'd0);
            chk("grant_in_reset", {30'd0, grant}, 32'd0);
        end else if (out_push) begin
            chk("ds_overflow", (ds_cnt >= CAP) ? 32'd1 : 32'd0, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_push", {31'd0, out_push}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant", {30'd0, grant}, {30'd0, e.g});
                chk("out_data", {26'd0, out_data}, {26'd0, e.d});
            end
        end else begin
            chk("idle_grant", {30'd0, grant}, 32'd0);
            chk("idle_data", {26'd0, out_data}, 32'd0);
            if (sb.size() != 0) begin
                chk("missing_push", {31'd0, out_push}, 32'd1);
                void'(sb.pop_front());
            end
        end
        seen_push = reset && out_push;
        if (log_en && (vc0_pop || vc1_pop)) dut_log.push_back(vc1_pop);
    end

    // One clock of the environment models; inputs change 1 ns after the edge.
    task automatic tick();
        int n;
        @(posedge clk);
        d0_n = '0;
        d1_n = '0;
        if (!reset) begin
            streak = 0;
        end else begin
            if (exp1 || q1.size() == 0) streak = 0;
            else if (exp0 && streak < MAXB) streak++;
            if (exp0) begin
                d0_n = q0.pop_front();
                sb.push_back('{GNT_VC0, d0_n});
            end
            if (exp1) begin
                d1_n = q1.pop_front();
                sb.push_back('{GNT_VC1, d1_n});
            end
        end
        n = ds_cnt + (seen_push ? 1 : 0);
        if (n > 0 && $urandom_range(0, 99) < drain_pct) n--;
        ds_cnt = n;
        #1;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) break;
            tick();
        end
        chk("drain_timeout", q0.size() + q1.size() + sb.size(), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 3 cycles with both FIFOs holding data.
        load(3, 3);
        reset = 1'b0;
        drive();
        repeat (3) tick();
        reset = 1'b1;
        run_until_idle(40);

        // VC0-only traffic.
        load(5, 0);
        run_until_idle(40);

        // Starvation guard with both VCs backed up.
        load(10, 10);
        dut_log.delete();
        log_en = 1'b1;
        run_until_idle(60);
        log_en = 1'b0;
        begin
            bit pat[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
            chk("starve_len", dut_log.size(), 32'd20);
            for (int i = 0; i < 12; i++) begin
                if (i < dut_log.size())
                    chk("starve_pattern", {31'd0, dut_log[i]}, {31'd0, pat[i]});
            end
        end

        // Backpressure mid-burst.
        load(8, 8);
        repeat (2) tick();
        force_af = 1'b1;
        drive();
        repeat (3) tick();
        force_af = 1'b0;
        drive();
        run_until_idle(60);

        // Single VC1 word drains to empty.
        load(0, 1);
        run_until_idle(20);

        // Reset in the cycle after a pop.
        load(4, 0);
        tick();
        reset = 1'b0;
        drive();
        tick();
        chk("state_after_reset", {30'd0, dut.state_q}, {30'd0, IDLE});
        reset = 1'b1;
        drive();
        run_until_idle(40);

        // Random traffic, drain rate, backpressure and occasional reset.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 30 && q0.size() < 8) load($urandom_range(0, 2), 0);
            if ($urandom_range(0, 99) < 30 && q1.size() < 8) load(0, $urandom_range(0, 2));
            if ($urandom_range(0, 99) < 5) drain_pct = $urandom_range(20, 100);
            force_af = ($urandom_range(0, 99) < 10);
            reset    = ($urandom_range(0, 199) != 0);
            drive();
            tick();
        end
        force_af  = 1'b0;
        reset     = 1'b1;
        drain_pct = 100;
        drive();
        run_until_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
Name: vc_arbiter

Overview:
- Drains two virtual-channel FIFOs (VC0, VC1; 1-cycle registered read, data_out zero when not read) into one downstream FIFO.
- VC0 has strict priority. A starvation guard forces one VC1 word after MAX_VC0_BURST consecutive VC0 pops while VC1 is non-empty.
- Sits between the VC FIFOs and the transmit FIFO in the transaction layer; owns all pop/push sequencing.

Parameters:
- DATA_WIDTH, 6, word width of all FIFOs.
- MAX_VC0_BURST, 4, consecutive VC0 pops allowed while VC1 waits (legal range 1..15).
- BURST_CNT_W, 4, burst counter width; must hold MAX_VC0_BURST.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- vc0_empty  in  1  VC0 FIFO empty flag.
- vc1_empty  in  1  VC1 FIFO empty flag.
- vc0_data  in  DATA_WIDTH  VC0 FIFO read data, valid the cycle after vc0_pop.
- vc1_data  in  DATA_WIDTH  VC1 FIFO read data, valid the cycle after vc1_pop.
- out_full  in  1  downstream FIFO full.
- out_almost_full  in  1  downstream FIFO at size-1.
- vc0_pop  out  1  read enable to VC0.
- vc1_pop  out  1  read enable to VC1.
- out_push  out  1  write enable to downstream FIFO.
- out_data  out  DATA_WIDTH  downstream write data.
- grant  out  2  registered one-hot {VC1,VC0} of the word being pushed this cycle; 00 when idle.

Behaviour:
- Reset (reset==0 at posedge): all outputs 0, state IDLE, burst_cnt 0, in-flight flag cleared. A reset mid-transfer drops the in-flight word; no push occurs in the following cycle.
- pop_ok = !out_full && !out_almost_full. It is evaluated combinationally each cycle. Pops are combinational from the current state, flags and pop_ok.
- Exactly one of vc0_pop/vc1_pop may be high in a cycle. A pop is never issued to an empty FIFO.
- Latency: a pop in cycle N gives out_push=1 in cycle N+1, with out_data = the popped FIFO's data and grant set to that channel. Throughput is 1 word/cycle.
- Since push trails pop by one cycle and the downstream count updates after the push edge, the pop_ok rule guarantees the downstream FIFO never overflows.
- FSM states:
  - IDLE: nothing popped.
  - SERV0: VC0 popped this cycle.
  - SERV1: VC1 popped this cycle.
- Transitions, evaluated each cycle, are priority ordered:
  1. !pop_ok -> IDLE, no pop.
  2. !vc0_empty && (vc1_empty || burst_cnt < MAX_VC0_BURST) -> SERV0, vc0_pop=1.
  3. !vc1_empty -> SERV1, vc1_pop=1.
  4. Otherwise -> IDLE.
- burst_cnt rules:
  - Increments on a VC0 pop while vc1_empty==0, saturating at MAX_VC0_BURST.
  - Clears on any VC1 pop, or when vc1_empty==1.
- Both FIFOs empty: pop nothing, out_push follows the previous cycle's pop only.
- A FIFO going empty after a pop is seen through its flag one cycle later. The arbiter therefore relies on the flag, never on a count.
- Backpressure asserted mid-burst stalls pops; burst_cnt is held, not cleared.
- No push in a cycle without a prior pop: out_push=0, out_data=0, grant=00.

Optional Feature:
- Macro VC_ARBITER_STATS_EN.
- When defined: adds outputs vc0_grant_cnt and vc1_grant_cnt (16 bits each), incremented on each push for that channel, wrapping at 2^16, cleared by reset. Also adds output starve_event, a 1-cycle pulse when a VC1 pop is forced by the burst limit.
- When undefined: these ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package vc_pkg holds:
  - FSM state enum (IDLE, SERV0, SERV1).
  - Grant encodings (GNT_NONE=2'b00, GNT_VC0=2'b01, GNT_VC1=2'b10).
  - Default DATA_WIDTH constant.
- One sub-module, vc_out_stage: the registered push/mux stage. It takes the pop select and produces out_push, out_data and grant one cycle later.
- The arbiter FSM and burst counter stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both FIFOs non-empty -> all outputs 0, no pops. After release, first vc0_pop is in cycle 1 and first out_push in cycle 2.
- VC0-only traffic: VC0 holds 5 words, VC1 empty -> 5 consecutive vc0_pop, 5 pushes in order one cycle later, grant=01, burst_cnt stays 0.
- Starvation: both FIFOs hold 10 words, MAX_VC0_BURST=4 -> pop pattern 0,0,0,0,1,0,0,0,0,1,... and grant sequence matches, delayed one cycle.
- Backpressure: out_almost_full asserted mid-stream for 3 cycles -> pops stop in the same cycle, exactly one trailing push, no push to a full FIFO. Resumes on deassert with burst_cnt preserved.
- Drain to empty: VC1 holds 1 word, VC0 empty -> single vc1_pop, no second pop after vc1_empty rises, out_data equals the stored word.
- Mid-transfer reset: assert reset in the cycle after a pop -> no out_push in the next cycle, and the FSM is in IDLE.
